// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-requester Data_memory arbiter.
// Optional alignment checking is controlled by DMEM_ARB_ALIGN_CHECK_EN (see dmem_arbiter.sv).
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic REQ_CORE   = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

  localparam logic [2:0] ALIGN_MASK = 3'b111;

  function automatic logic is_misaligned(input logic [2:0] addr_lsb);
    return |(addr_lsb & ALIGN_MASK);
  endfunction

  function automatic logic [1:0] owner_onehot(input logic owner);
    return (owner == REQ_LOADER) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester handshake and Data_memory bus bundle for dmem_arbiter.
// Handshake: a request (req, we, addr, wdata) is held stable until gnt; it is accepted in the
// cycle where req & gnt, and completes with a one-cycle ack (plus err/rdata) two cycles later.
interface dmem_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              ack0;
  logic              ack1;
  logic              err0;
  logic              err1;
  logic [DATA_W-1:0] rdata;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_Data_write;
  logic              mem_MemWrite;
  logic              mem_MemRead;
  logic [DATA_W-1:0] mem_Data_read;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_Data_read,
    output gnt0, gnt1, ack0, ack1, err0, err1, rdata,
           mem_address, mem_Data_write, mem_MemWrite, mem_MemRead
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_Data_read,
    input  gnt0, gnt1, ack0, ack1, err0, err1, rdata,
           mem_address, mem_Data_write, mem_MemWrite, mem_MemRead
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone request wins, a tie goes to the requester that did not win last.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_owner == REQ_LOADER) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer in front of single-port Data_memory: grant, one access cycle, ack.
// Define DMEM_ARB_ALIGN_CHECK_EN to reject non-8-byte-aligned accesses with err instead of a strobe.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) (
  input  logic          Clk,
  input  logic          Rst_n,
  dmem_arbiter_if.slave bus,
  output state_t        state_dbg
);

  state_t            state_q;
  state_t            state_d;

  logic [1:0]        req_v;
  logic [1:0]        arb_gnt;
  logic [1:0]        gnt_v;
  logic              accept;
  logic              win;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              owner_q;
  logic              we_q;
  logic              last_owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        ack_q;

  logic              in_access;
  logic              skip;
  logic              strobe_en;

  assign req_v = {bus.req1, bus.req0};

  rr_arb2 u_rr_arb2 (
    .req        (req_v),
    .last_owner (last_owner_q),
    .gnt        (arb_gnt)
  );

  // Grants are only offered while idle; ACCESS and RESP never accept.
  assign gnt_v  = (state_q == IDLE) ? arb_gnt : 2'b00;
  assign accept = |gnt_v;
  assign win    = gnt_v[1];

  assign sel_we    = win ? bus.we1    : bus.we0;
  assign sel_addr  = win ? bus.addr1  : bus.addr0;
  assign sel_wdata = win ? bus.wdata1 : bus.wdata0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Last_owner resets to the loader so the core wins the first tie.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      owner_q      <= REQ_CORE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      last_owner_q <= REQ_LOADER;
    end else if (accept) begin
      owner_q      <= win;
      we_q         <= sel_we;
      addr_q       <= sel_addr;
      wdata_q      <= sel_wdata;
      last_owner_q <= win;
    end
  end

  assign in_access = (state_q == ACCESS);

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  logic       skip_q;
  logic [1:0] err_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)      skip_q <= 1'b0;
    else if (accept) skip_q <= is_misaligned(sel_addr[2:0]);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) err_q <= 2'b00;
    else        err_q <= (in_access && skip_q) ? owner_onehot(owner_q) : 2'b00;
  end

  assign skip     = skip_q;
  assign bus.err0 = err_q[0];
  assign bus.err1 = err_q[1];
`else
  assign skip     = 1'b0;
  assign bus.err0 = 1'b0;
  assign bus.err1 = 1'b0;
`endif

  // Strobes are decoded from the async-reset state, so reset drops them at once.
  assign strobe_en = in_access && !skip;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                      rdata_q <= '0;
    else if (strobe_en && !we_q)     rdata_q <= bus.mem_Data_read;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) ack_q <= 2'b00;
    else        ack_q <= in_access ? owner_onehot(owner_q) : 2'b00;
  end

  assign bus.gnt0           = gnt_v[0];
  assign bus.gnt1           = gnt_v[1];
  assign bus.ack0           = ack_q[0];
  assign bus.ack1           = ack_q[1];
  assign bus.rdata          = rdata_q;
  assign bus.mem_address    = addr_q;
  assign bus.mem_Data_write = wdata_q;
  assign bus.mem_MemWrite   = strobe_en &&  we_q;
  assign bus.mem_MemRead    = strobe_en && !we_q;

  assign state_dbg = state_q;

endmodule
